// File: rtl/lsu_pkg.sv
// Shared types and encodings for the load/store bus controller.
// Load/store type values follow the funct3 field of the instruction.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  localparam logic [1:0] SB = 2'b00;
  localparam logic [1:0] SH = 2'b01;
  localparam logic [1:0] SW = 2'b10;

  // Undefined load encodings behave as full-word accesses.
  function automatic logic is_misaligned(input logic       we,
                                         input logic [2:0] ld_type,
                                         input logic [1:0] st_type,
                                         input logic [1:0] off);
    logic half;
    logic word;
    if (we) begin
      half = (st_type == SH);
      word = st_type[1];
    end else begin
      half = (ld_type == LH) || (ld_type == LHU);
      word = !((ld_type == LB) || (ld_type == LBU) || half);
    end
    return (half && off[0]) || (word && (off != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_bus_ctrl_if.sv
// Pipeline request/response and data-bus signals of the load/store unit.
// slave = the controller, master = pipeline plus bus model.
interface lsu_bus_ctrl_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              i_req_vld;
  logic              o_req_rdy;
  logic [ADDR_W-1:0] i_addr;
  logic [31:0]       i_wdata;
  logic              i_mem_rw;
  logic [2:0]        i_load_type;
  logic [1:0]        i_store_type;
  logic              o_rsp_vld;
  logic [31:0]       o_rdata;
  logic              o_stall;
  logic              o_bus_err;
  logic              o_misalign;
  logic              o_bus_req;
  logic              o_bus_we;
  logic [ADDR_W-1:0] o_bus_addr;
  logic [3:0]        o_bus_be;
  logic [31:0]       o_bus_wdata;
  logic              i_bus_ack;
  logic [31:0]       i_bus_rdata;

  modport slave (
    input  i_req_vld, i_addr, i_wdata, i_mem_rw, i_load_type, i_store_type,
    input  i_bus_ack, i_bus_rdata,
    output o_req_rdy, o_rsp_vld, o_rdata, o_stall, o_bus_err, o_misalign,
    output o_bus_req, o_bus_we, o_bus_addr, o_bus_be, o_bus_wdata
  );

  modport master (
    output i_req_vld, i_addr, i_wdata, i_mem_rw, i_load_type, i_store_type,
    output i_bus_ack, i_bus_rdata,
    input  o_req_rdy, o_rsp_vld, o_rdata, o_stall, o_bus_err, o_misalign,
    input  o_bus_req, o_bus_we, o_bus_addr, o_bus_be, o_bus_wdata
  );
endinterface

// File: rtl/lsu_data_fmt.sv
// Combinational store lane placement and load extract/extension.
// Kept separate so a future cache path can reuse the same formatting.
module lsu_data_fmt
  import lsu_pkg::*;
(
  input  logic [1:0]  st_type_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_data_o,
  input  logic [2:0]  ld_type_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] ld_data_i,
  output logic [31:0] ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_be_o   = 4'b1111;
    st_data_o = st_data_i;
    case (st_type_i)
      SB: begin
        st_be_o   = 4'b0001 << st_off_i;
        st_data_o = {4{st_data_i[7:0]}};
      end
      SH: begin
        st_be_o   = 4'b0011 << {st_off_i[1], 1'b0};
        st_data_o = {2{st_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (ld_off_i)
      2'd0:    ld_byte = ld_data_i[7:0];
      2'd1:    ld_byte = ld_data_i[15:8];
      2'd2:    ld_byte = ld_data_i[23:16];
      default: ld_byte = ld_data_i[31:24];
    endcase
    ld_half = ld_off_i[1] ? ld_data_i[31:16] : ld_data_i[15:0];

    ld_data_o = ld_data_i;
    case (ld_type_i)
      LB:      ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      LBU:     ld_data_o = {24'd0, ld_byte};
      LH:      ld_data_o = {{16{ld_half[15]}}, ld_half};
      LHU:     ld_data_o = {16'd0, ld_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// Multi-cycle load/store bus controller with optional timeout abort.
// Optional misaligned-access trap: define LSU_MISALIGN_TRAP_EN.
//
// state | meaning
// IDLE  | ready for a request; stall follows i_req_vld
// BUS   | bus request held until ack or timeout
// DONE  | one-cycle response (rsp_vld, optional bus_err/misalign)
module lsu_bus_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input logic           i_clk,
  input logic           i_rst_n,
  lsu_bus_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = (BUS_TIMEOUT > 2) ? $clog2(BUS_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUS_TIMEOUT - 1);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-3:0] waddr_q, waddr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [2:0]        ld_type_q, ld_type_d;
  logic [1:0]        off_q, off_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mis_q, mis_d;

  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_fmt;
  logic        timeout;
  logic        trap;

  lsu_data_fmt u_fmt (
    .st_type_i (bus.i_store_type),
    .st_off_i  (bus.i_addr[1:0]),
    .st_data_i (bus.i_wdata),
    .st_be_o   (st_be),
    .st_data_o (st_wdata),
    .ld_type_i (ld_type_q),
    .ld_off_i  (off_q),
    .ld_data_i (bus.i_bus_rdata),
    .ld_data_o (ld_fmt)
  );

  assign timeout = (BUS_TIMEOUT != 0) && (cnt_q == CNT_LAST);

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = is_misaligned(bus.i_mem_rw, bus.i_load_type,
                              bus.i_store_type, bus.i_addr[1:0]);
`else
  assign trap = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      waddr_q   <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      ld_type_q <= '0;
      off_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      waddr_q   <= waddr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      ld_type_q <= ld_type_d;
      off_q     <= off_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      mis_q     <= mis_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    waddr_d   = waddr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    ld_type_d = ld_type_q;
    off_d     = off_q;
    rdata_d   = rdata_q;
    err_d     = 1'b0;
    cnt_d     = cnt_q;
    mis_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.i_req_vld) begin
          waddr_d   = bus.i_addr[ADDR_W-1:2];
          be_d      = bus.i_mem_rw ? st_be : 4'b1111;
          wdata_d   = bus.i_mem_rw ? st_wdata : 32'd0;
          we_d      = bus.i_mem_rw;
          ld_type_d = bus.i_load_type;
          off_d     = bus.i_addr[1:0];
          rdata_d   = 32'd0;
          cnt_d     = '0;
          if (trap) begin
            mis_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = BUS;
          end
        end
      end
      BUS: begin
        cnt_d = cnt_q + 1'b1;
        // Ack takes priority over a timeout landing in the same cycle.
        if (bus.i_bus_ack) begin
          rdata_d = we_q ? 32'd0 : ld_fmt;
          state_d = DONE;
        end else if (timeout) begin
          rdata_d = 32'd0;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.o_req_rdy   = (state_q == IDLE);
  assign bus.o_stall     = (state_q == IDLE) ? bus.i_req_vld : (state_q == BUS);
  assign bus.o_rsp_vld   = (state_q == DONE);
  assign bus.o_rdata     = rdata_q;
  assign bus.o_bus_err   = err_q;
  assign bus.o_misalign  = mis_q;
  assign bus.o_bus_req   = (state_q == BUS);
  assign bus.o_bus_we    = we_q;
  assign bus.o_bus_addr  = {waddr_q, 2'b00};
  assign bus.o_bus_be    = be_q;
  assign bus.o_bus_wdata = wdata_q;

endmodule

// File: doc/lsu_bus_ctrl.md
Name: lsu_bus_ctrl

Overview:
- Multi-cycle load/store unit. Consumes the MEM-stage control fields MemRW, load_type and store_type, and runs the matching data-memory bus transaction.
- Sits between the pipeline MEM stage and the data-memory/peripheral bus.
- Generates byte enables and lane-shifted write data for stores. Extracts and sign/zero-extends load data.
- Asserts stall while a transaction is in flight so the pipeline holds.

Parameters:
ADDR_W, 32, byte-address width.
BUS_TIMEOUT, 255, maximum cycles to wait for i_bus_ack before aborting; 0 disables the timeout.

Ports:
i_clk  in  1  clock; all state is updated on the rising edge.
i_rst_n  in  1  asynchronous active-low reset.
i_req_vld  in  1  MEM-stage access request.
o_req_rdy  out  1  unit idle; a request is accepted when i_req_vld && o_req_rdy.
i_addr  in  ADDR_W  byte address.
i_wdata  in  32  store data, taken from the low bits.
i_mem_rw  in  1  1 = store, 0 = load.
i_load_type  in  3  funct3 load encoding.
i_store_type  in  2  funct3[1:0] store encoding.
o_rsp_vld  out  1  one-cycle completion pulse.
o_rdata  out  32  formatted load data; valid with o_rsp_vld.
o_stall  out  1  pipeline hold.
o_bus_err  out  1  one-cycle pulse on timeout.
o_misalign  out  1  one-cycle pulse on a misaligned access (see Optional Feature).
o_bus_req  out  1  bus request, held until ack.
o_bus_we  out  1  bus write enable.
o_bus_addr  out  ADDR_W  word-aligned address: i_addr with bits [1:0] forced to 0.
o_bus_be  out  4  byte enables.
o_bus_wdata  out  32  lane-aligned write data.
i_bus_ack  in  1  bus completion strobe.
i_bus_rdata  in  32  read data; valid with i_bus_ack.

Behaviour:
- Reset (async, i_rst_n=0):
  - state=IDLE; all outputs 0 except o_req_rdy=1.
  - Captured registers and timeout counter cleared.
  - Reset mid-transaction drops o_bus_req immediately. No o_rsp_vld is produced.
- FSM states: IDLE, BUS, DONE.
- IDLE:
  - o_req_rdy=1, o_stall=i_req_vld.
  - On accept, register addr, be, wdata, we, load_type and byte offset (addr[1:0]); go to BUS.
- BUS:
  - o_bus_req=1; bus outputs held stable from registers; o_stall=1; counter increments each cycle.
  - On i_bus_ack: capture formatted i_bus_rdata; go to DONE.
  - If BUS_TIMEOUT!=0 and counter==BUS_TIMEOUT-1 without ack: go to DONE with rdata=0 and o_bus_err pulsed in DONE.
  - If ack arrives in the same cycle as the timeout, ack wins.
- DONE:
  - o_rsp_vld=1, o_stall=0, o_req_rdy=0; return to IDLE next cycle.
- Latency:
  - Accept to o_rsp_vld is N+2 cycles, where N = cycles of i_bus_ack delay after o_bus_req rises (N=0: ack in the first BUS cycle).
  - Back-to-back throughput is one access per N+3 cycles.
- Store formatting (store_type):
  - 00 SB: be=4'b0001<<a[1:0]; wdata=byte replicated x4.
  - 01 SH: be=4'b0011<<(2*a[1]); wdata=halfword replicated x2.
  - 10/11 SW: be=4'b1111; wdata unchanged.
  - On stores, o_rdata=0.
- Load formatting (load_type):
  - Loads drive o_bus_be=4'b1111 and o_bus_we=0.
  - Lane is selected by a[1:0] for bytes and a[1] for halves.
  - 000 LB: sign-extend byte. 100 LBU: zero-extend byte.
  - 001 LH: sign-extend half. 101 LHU: zero-extend half.
  - 010 and all undefined encodings: full word.
- i_req_vld while not in IDLE is ignored; the pipeline is held by o_stall.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined:
  - A halfword access with a[0]=1, or a word access with a[1:0]!=0, issues no bus cycle.
  - The FSM goes IDLE->DONE directly; o_misalign and o_rsp_vld pulse together, with o_rdata=0.
- Undefined:
  - o_misalign is tied 0.
  - Low address bits beyond the lane selection are ignored: LH at offset 1 uses lane a[1], LW at offset 2 reads the aligned word.

Decomposition:
- Package lsu_pkg holds:
  - state enum (IDLE/BUS/DONE);
  - load_type localparams LB/LH/LW/LBU/LHU;
  - store_type localparams SB/SH/SW.
- One sub-module, lsu_data_fmt: combinational store byte-enable/replication and load extract/extension. It is shared with any future cache path.

Test Plan:
- SB addr 0x1003, wdata 0x000000AB, ack N=0 -> be=4'b1000, bus_wdata=0xABABABAB, bus_addr=0x1000, we=1; rsp_vld 2 cycles after accept.
- LB addr 0x2001, bus_rdata 0x123480FF -> o_rdata=0xFFFFFF80. Same access as LBU -> 0x00000080.
- LH addr 0x2002, bus_rdata 0x8001BEEF -> 0xFFFF8001. LHU -> 0x00008001. LW -> 0x8001BEEF.
- LW with ack delayed 3 cycles -> o_bus_req high 4 cycles; o_stall high from accept until DONE; one rsp_vld pulse; a second i_req_vld in BUS is ignored.
- BUS_TIMEOUT=4, no ack -> bus_req low after 4 BUS cycles; o_bus_err and o_rsp_vld pulse together with rdata=0. Assert i_rst_n=0 during BUS -> bus_req drops asynchronously; no rsp.
- With LSU_MISALIGN_TRAP_EN: LW addr 0x2002 -> no bus_req; o_misalign=o_rsp_vld=1 one cycle after accept.
